// File: rtl/usb_rx_pkg.sv
// Shared constants and FSM state encoding for the USB receive bit decoder.
package usb_rx_pkg;

    localparam int CLKS_PER_BIT = 8;
    localparam int SAMPLE_PHASE = 3;
    localparam int STUFF_LIMIT  = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        EOP_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Free-running up-counter: counts 0 .. rollover_val-1 then wraps; clear forces 0.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q >= rollover_val - NUM_CNT_BITS'(1)) begin
                count_d = '0;
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB receive NRZI bit decoder with bit-unstuffing, byte boundary flags and EOP detect.
// Define USB_RX_STUFF_ERR_EN to report bit-stuff violations on stuff_err.
//
// state    | meaning
// IDLE     | line idle, waiting for J->K packet start edge
// RECEIVE  | sampling mid-bit, NRZI decoding and unstuffing
// EOP_WAIT | SE0 seen, eop held until J sampled
module usb_rx_bit_decoder
    import usb_rx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        d_plus,
    input  logic        d_minus,
    input  logic        timer_clear,
    output logic        edge_start,
    output logic        shift_enable,
    output logic [15:0] rcv_data,
    output logic        one_byte,
    output logic        two_byte,
    output logic        eop,
    output logic        stuff_err
);

    localparam logic [3:0] PHASE_ROLL = 4'(CLKS_PER_BIT);
    localparam logic [3:0] PHASE_SAMP = 4'(SAMPLE_PHASE);
    localparam logic [2:0] ONES_MAX   = 3'(STUFF_LIMIT);

    state_t      state_q, state_d;
    logic        dp_last_q, dp_last_d;
    logic        prev_level_q, prev_level_d;
    logic [2:0]  ones_q, ones_d;
    logic [3:0]  count_q, count_d, count_inc;
    logic [15:0] rcv_data_q, rcv_data_d;
    logic        edge_start_q, edge_start_d;
    logic        shift_enable_q, shift_enable_d;
    logic        one_byte_q, one_byte_d;
    logic        two_byte_q, two_byte_d;
    logic        eop_q, eop_d;

    logic [3:0]  phase;
    logic        phase_clear, sample, se0, line_j, nrzi_bit;

    assign dp_last_d   = d_plus;
    assign phase_clear = timer_clear || (state_q == IDLE) || (d_plus != dp_last_q);
    assign sample      = (phase == PHASE_SAMP);
    assign se0         = !d_plus && !d_minus;
    assign line_j      = d_plus && !d_minus;
    assign nrzi_bit    = (d_plus == prev_level_q);

    flex_counter #(.NUM_CNT_BITS(4)) u_phase (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (phase_clear),
        .count_enable (1'b1),
        .rollover_val (PHASE_ROLL),
        .count_out    (phase)
    );

    always_comb begin
        state_d        = state_q;
        prev_level_d   = prev_level_q;
        ones_d         = ones_q;
        count_d        = count_q;
        rcv_data_d     = rcv_data_q;
        edge_start_d   = 1'b0;
        shift_enable_d = 1'b0;
        one_byte_d     = one_byte_q;
        two_byte_d     = two_byte_q;
        eop_d          = eop_q;
        count_inc      = count_q + 4'd1;

        if (timer_clear) begin
            state_d      = IDLE;
            prev_level_d = 1'b1;
            ones_d       = '0;
            count_d      = '0;
            one_byte_d   = 1'b0;
            two_byte_d   = 1'b0;
            eop_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dp_last_q && !d_plus) begin
                        edge_start_d = 1'b1;
                        prev_level_d = 1'b1;
                        ones_d       = '0;
                        count_d      = '0;
                        one_byte_d   = 1'b0;
                        two_byte_d   = 1'b0;
                        state_d      = RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (sample) begin
                        if (se0) begin
                            eop_d   = 1'b1;
                            state_d = EOP_WAIT;
                        end else begin
                            prev_level_d = d_plus;
                            if (ones_q == ONES_MAX) begin
                                ones_d = '0;
                            end else begin
                                shift_enable_d = 1'b1;
                                rcv_data_d     = {nrzi_bit, rcv_data_q[15:1]};
                                ones_d         = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                                count_d        = count_inc;
                                // boundaries are only reachable after >= 8 / 16 shifts
                                one_byte_d     = (count_inc[2:0] == 3'd0);
                                two_byte_d     = (count_inc == 4'd0);
                            end
                        end
                    end
                end
                EOP_WAIT: begin
                    eop_d = 1'b1;
                    if (sample && line_j) begin
                        eop_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            dp_last_q      <= 1'b0;
            prev_level_q   <= 1'b1;
            ones_q         <= '0;
            count_q        <= '0;
            rcv_data_q     <= 16'h0000;
            edge_start_q   <= 1'b0;
            shift_enable_q <= 1'b0;
            one_byte_q     <= 1'b0;
            two_byte_q     <= 1'b0;
            eop_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            dp_last_q      <= dp_last_d;
            prev_level_q   <= prev_level_d;
            ones_q         <= ones_d;
            count_q        <= count_d;
            rcv_data_q     <= rcv_data_d;
            edge_start_q   <= edge_start_d;
            shift_enable_q <= shift_enable_d;
            one_byte_q     <= one_byte_d;
            two_byte_q     <= two_byte_d;
            eop_q          <= eop_d;
        end
    end

`ifdef USB_RX_STUFF_ERR_EN
    logic stuff_err_q, stuff_err_d;

    always_comb begin
        stuff_err_d = !timer_clear && (state_q == RECEIVE) && sample && !se0
                      && (ones_q == ONES_MAX) && nrzi_bit;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stuff_err_q <= 1'b0;
        end else begin
            stuff_err_q <= stuff_err_d;
        end
    end

    assign stuff_err = stuff_err_q;
`else
    assign stuff_err = 1'b0;
`endif

    assign edge_start   = edge_start_q;
    assign shift_enable = shift_enable_q;
    assign rcv_data     = rcv_data_q;
    assign one_byte     = one_byte_q;
    assign two_byte     = two_byte_q;
    assign eop          = eop_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Scoreboard bench for usb_rx_bit_decoder: driver pushes expected bits, monitor checks each shift.
module tb_usb_rx_bit_decoder;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        d_plus = 1'b1;
    logic        d_minus = 1'b0;
    logic        timer_clear = 1'b0;
    logic        edge_start, shift_enable, one_byte, two_byte, eop, stuff_err;
    logic [15:0] rcv_data;

`ifdef USB_RX_STUFF_ERR_EN
    localparam int EXP_STUFF = 1;
`else
    localparam int EXP_STUFF = 0;
`endif

    usb_rx_bit_decoder dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .timer_clear  (timer_clear),
        .edge_start   (edge_start),
        .shift_enable (shift_enable),
        .rcv_data     (rcv_data),
        .one_byte     (one_byte),
        .two_byte     (two_byte),
        .eop          (eop),
        .stuff_err    (stuff_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic ob;
        logic tb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   n_shift = 0;
    int   n_edge = 0;
    int   n_stuff = 0;
    int   n_sent = 0;
    logic line_lvl = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (n_rst) begin
            if (edge_start) n_edge++;
            if (stuff_err) n_stuff++;
            if (shift_enable) begin
                n_shift++;
                check("shift_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("shift_bit", 32'(rcv_data[15]), 32'(e.b));
                    check("shift_one_byte", 32'(one_byte), 32'(e.ob));
                    check("shift_two_byte", 32'(two_byte), 32'(e.tb));
                end
            end
        end
    end

    task automatic drive(input logic dp, input logic dm, input int cycles);
        @(posedge clk);
        #1;
        d_plus  = dp;
        d_minus = dm;
        repeat (cycles - 1) @(posedge clk);
    endtask

    task automatic send_bit(input logic b, input logic accepted);
        exp_t e;
        if (!b) line_lvl = ~line_lvl;
        if (accepted) begin
            n_sent++;
            e.b  = b;
            e.ob = (n_sent % 8 == 0);
            e.tb = (n_sent % 16 == 0);
            exp_q.push_back(e);
        end
        drive(line_lvl, ~line_lvl, 8);
    endtask

    task automatic send_sync();
        n_sent = 0;
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
    endtask

    task automatic send_j();
        line_lvl = 1'b1;
        drive(1'b1, 1'b0, 8);
    endtask

    task automatic pulse_timer_clear();
        @(posedge clk);
        #1 timer_clear = 1'b1;
        @(posedge clk);
        #1 timer_clear = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int e0, s0, st0;
        logic [7:0] pid;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rcv_data", 32'(rcv_data), 32'h0);
        check("reset_outputs", 32'({edge_start, shift_enable, one_byte, two_byte, eop, stuff_err}), 0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        send_j();
        send_j();

        // packet A: SYNC + OUT PID, then two SE0 bit times and J
        e0 = n_edge; s0 = n_shift;
        send_sync();
        @(negedge clk);
        check("a_edge_start_count", 32'(n_edge - e0), 1);
        check("a_sync_shifts", 32'(n_shift - s0), 8);
        check("a_sync_rcv_hi", 32'(rcv_data[15:8]), 32'h80);
        check("a_sync_one_byte", 32'(one_byte), 1);
        check("a_sync_two_byte", 32'(two_byte), 0);
        pid = 8'hE1;
        for (int i = 0; i < 8; i++) send_bit(pid[i], 1'b1);
        @(negedge clk);
        check("a_pid_rcv", 32'(rcv_data), 32'hE180);
        check("a_pid_rcv_nib", 32'(rcv_data[11:8]), 32'h1);
        check("a_pid_two_byte", 32'(two_byte), 1);
        drive(1'b0, 1'b0, 8);
        @(negedge clk);
        check("a_eop_rise", 32'(eop), 1);
        check("a_eop_hold_flags", 32'({one_byte, two_byte}), 32'h3);
        drive(1'b0, 1'b0, 8);
        @(negedge clk);
        check("a_eop_held", 32'(eop), 1);
        send_j();
        @(negedge clk);
        check("a_eop_fall", 32'(eop), 0);
        send_j();

        // packet B: six 1s followed by a stuffed 0, then EOP with a J/K glitch
        e0 = n_edge; st0 = n_stuff;
        send_sync();
        send_bit(1'b0, 1'b1);
        s0 = n_shift;
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        @(negedge clk);
        check("b_stuff_shifts", 32'(n_shift - s0), 6);
        check("b_no_stuff_err", 32'(n_stuff - st0), 0);
        drive(1'b0, 1'b0, 8);
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 5);
        @(negedge clk);
        check("b_eop_after_glitch", 32'(eop), 1);
        check("b_no_edge_in_eop", 32'(n_edge - e0), 1);
        send_j();
        @(negedge clk);
        check("b_eop_fall", 32'(eop), 0);
        send_j();

        // packet C: seven 1s (violation), one more 0, then timer_clear
        st0 = n_stuff;
        send_sync();
        send_bit(1'b0, 1'b1);
        s0 = n_shift;
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        @(negedge clk);
        check("c_violation_shifts", 32'(n_shift - s0), 7);
        check("c_stuff_err_cycles", 32'(n_stuff - st0), 32'(EXP_STUFF));
        check("c_flags_before_clear", 32'({one_byte, two_byte}), 32'h3);
        pulse_timer_clear();
        check("c_clear_flags", 32'({one_byte, two_byte, eop}), 0);
        check("c_clear_keeps_rcv", 32'(rcv_data), 32'h7E80);
        send_j();
        send_j();

        // packet D: timer_clear after 5 bits, then a fresh packet
        e0 = n_edge; s0 = n_shift;
        n_sent = 0;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        pulse_timer_clear();
        check("d_clear_one_byte", 32'(one_byte), 0);
        check("d_partial_shifts", 32'(n_shift - s0), 5);
        send_j();
        send_j();
        check("d_no_edge_idle_kj", 32'(n_edge - e0), 1);
        send_sync();
        @(negedge clk);
        check("d_fresh_edge", 32'(n_edge - e0), 2);
        check("d_fresh_one_byte", 32'(one_byte), 1);
        check("d_fresh_rcv_hi", 32'(rcv_data[15:8]), 32'h80);

        // asynchronous reset mid-packet, then wait for a fresh J->K
        #2 n_rst = 1'b0;
        #1;
        check("rst_rcv_data", 32'(rcv_data), 32'h0);
        check("rst_outputs", 32'({edge_start, shift_enable, one_byte, two_byte, eop}), 0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        e0 = n_edge; s0 = n_shift;
        send_bit(1'b1, 1'b0);
        send_j();
        check("rst_no_edge", 32'(n_edge - e0), 0);
        check("rst_no_shift", 32'(n_shift - s0), 0);
        send_sync();
        @(negedge clk);
        check("rst_resume_edge", 32'(n_edge - e0), 1);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
